// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and helpers for the hex keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  function automatic logic [1:0] row_index(input logic [3:0] onehot);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (onehot[i]) idx = i[1:0];
    return idx;
  endfunction
endpackage

// File: rtl/row_sync.sv
// row_sync: W-bit two-flop synchronizer for asynchronous level inputs
module row_sync #(
  parameter int W = 4,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= INIT;
      q <= INIT;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 keypad, debounces presses/releases and
// assembles the last two accepted hex digits into an 8-bit value
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [7:0] value,
  input  logic       clear
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  state_t state, state_nx;
  logic [1:0] col, row;
  logic [3:0] rows_s, rows_low, pattern, code;
  logic [DW-1:0] dwell;
  logic [CW-1:0] cnt;
  logic dwell_end, single, match, done, latch, advance, accept;
  row_sync #(.W(4), .INIT(4'hF)) u_sync (.clk(clk), .rst_n(rst_n), .d(row_n), .q(rows_s));
  assign rows_low = ~rows_s;
  assign dwell_end = dwell == DW'(SCAN_DIV - 1);
  assign single = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
  assign match = (state == PRESSED) ? (rows_s == 4'hF) : (rows_s == pattern);
  assign done = match && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign code = KEY_MAP[{row, col}];
  assign col_n = ~(4'b0001 << col);
  always_comb begin
    state_nx = state;
    latch = 1'b0;
    advance = 1'b0;
    accept = 1'b0;
    case (state)
      SCAN: if (dwell_end) begin
        latch = single;
        advance = !single;
        state_nx = single ? DEBOUNCE : SCAN;
      end
      DEBOUNCE: begin
        advance = !match;
        accept = done;
        state_nx = !match ? SCAN : done ? PRESSED : DEBOUNCE;
      end
      PRESSED: begin
        advance = done;
        state_nx = done ? SCAN : PRESSED;
      end
      default: state_nx = SCAN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      col <= 2'd0;
      row <= 2'd0;
      pattern <= 4'hF;
      dwell <= '0;
      cnt <= '0;
      key_code <= 4'd0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      value <= 8'd0;
    end else begin
      state <= state_nx;
      col <= advance ? col + 2'd1 : col;
      row <= latch ? row_index(rows_low) : row;
      pattern <= latch ? rows_s : pattern;
      dwell <= (state == SCAN && !dwell_end) ? dwell + DW'(1) : '0;
      // counter restarts on every state change and on any broken run
      cnt <= (state == SCAN || state_nx != state || !match) ? '0
           : cnt + CW'(cnt != CW'(DEBOUNCE_CYCLES));
      key_code <= accept ? code : key_code;
      key_valid <= accept;
      key_held <= state_nx == PRESSED;
      value <= clear ? 8'd0 : accept ? {value[3:0], code} : value;
    end
  end
endmodule

// File: doc/hex_keypad_scanner.md
# hex_keypad_scanner

Reads a 4x4 hex matrix keypad and turns key presses into debounced 4-bit hex codes. It is the input-side counterpart of the seven-segment digit path: the display path writes hex digits out to the user, and this block reads hex digits in. It also assembles the last two digits into an 8-bit operand, so it can replace the slide-switch operand entry in the adder design.

## Interface
Parameters:
- SCAN_DIV, 16: clock cycles each column stays driven; legal range is 4 or more.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release; legal range is 2 or more.

Ports:
- clk, input, 1: single clock; all state is on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- col_n, output, 4: column drive, active-low, exactly one bit low at any time.
- row_n, input, 4: row sense, active-low, pulled up externally, asynchronous to clk.
- key_code, output, 4: hex code of the most recently accepted key.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_held, output, 1: high while the accepted key is still considered pressed.
- value, output, 8: last two accepted digits, with the newest digit in bits [3:0].
- clear, input, 1: synchronous; sets value to 0.

## Operation
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized rows (rows_s).
- Key map, [row][col], codes in hex:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E, 0, F, D
- The FSM has three states: SCAN, DEBOUNCE and PRESSED.
- SCAN:
  - The active column rotates 0→1→2→3→0, one step every SCAN_DIV cycles.
  - rows_s is sampled on the last cycle of each dwell.
  - If exactly one row is low, latch row and column and go to DEBOUNCE.
  - If no row is low, or two or more rows are low (ghosting), advance to the next column.
- DEBOUNCE:
  - The column is frozen and a counter counts cycles where rows_s equals the latched pattern.
  - On any mismatch, return to SCAN and advance the column.
  - When the counter reaches DEBOUNCE_CYCLES, go to PRESSED:
    - key_code is set to the mapped code;
    - key_valid pulses for 1 cycle;
    - value is set to {value[3:0], code}.
- PRESSED:
  - The column stays frozen and key_held is 1.
  - The counter counts consecutive cycles with all rows_s high and resets to 0 on any low row.
  - When it reaches DEBOUNCE_CYCLES, key_held goes to 0 and the FSM returns to SCAN at the next column.
  - A second key pressed during PRESSED is ignored; there is no auto-repeat.
- clear:
  - clear sets value to 0 and has priority over a same-cycle key_valid update (value becomes 0).
  - key_code is unaffected.
- Asserting rst_n low at any time takes effect immediately and restores the reset values below. This includes mid-debounce and mid-hold; no partial key is emitted.

## Timing
- Reset values:
  - col_n = 4'b1110;
  - key_code = 0, key_valid = 0, key_held = 0, value = 0;
  - state SCAN, counters 0.
- A stable press reaches key_valid after: 2 sync cycles + up to 4·SCAN_DIV cycles of scan alignment + DEBOUNCE_CYCLES.
- key_valid is high for exactly 1 cycle per physical press.
- key_code and value update in the same cycle that key_valid is high.
- key_held rises together with key_valid and falls DEBOUNCE_CYCLES cycles after the rows are stable high (plus 2 sync cycles).
- The column counter wraps 3→0 with no idle cycle.
- Counters saturate at DEBOUNCE_CYCLES and never wrap.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, PRESSED);
  - the 16-entry KEY_MAP constant, indexed {row, col};
  - a function that converts a one-hot row to its index.
- Sub-module row_sync is a 4-bit, 2-flop synchronizer, also reusable for keys and switches elsewhere.
- Top level contains the FSM, dwell counter, debounce counter and value register.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset: hold rst_n=0 → col_n=1110, value=00, key_valid=0. Release with no key pressed → col_n cycles 1110, 1101, 1011, 0111 every 4 cycles, with no pulses.
- Press row1/col2 and hold for 100 cycles → exactly one key_valid, key_code=6, value=06, key_held=1 until 8+2 cycles after release.
- Press 1 then press D with full releases between → value=1D.
- Apply clear in the cycle key_valid would fire for the second key → value=00.
- Bounce: toggle row0/col0 every 3 cycles for 40 cycles, then hold it stable → exactly one key_valid, key_code=1. Bouncing for fewer than 8 cycles then releasing → no pulse.
- Ghosting: rows 0 and 2 both low on col1 → no key_valid, scan continues. A second key pressed while the first is held → no extra pulse.
- Reset mid-operation: rst_n=0 during DEBOUNCE and during PRESSED → outputs at reset values immediately, and no key_valid is emitted after rst_n returns high while the key stays released.
